// File: rtl/glitch_pulse_seq.sv
// glitch_pulse_seq: armed trigger-to-glitch sequencer emitting a delayed train of pulses
module glitch_pulse_seq #(
  parameter int DELAY_W     = 32,
  parameter int WIDTH_W     = 16,
  parameter int COUNT_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DELAY_W-1:0] cfg_delay_i,
  input  logic [WIDTH_W-1:0] cfg_width_i,
  input  logic [WIDTH_W-1:0] cfg_gap_i,
  input  logic [COUNT_W-1:0] cfg_count_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               trigger_i,
  output logic               pulse_o,
  output logic               pulse_en_o,
  output logic               armed_o,
  output logic               busy_o,
  output logic               done_o
);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;
  state_t state_q, state_d;
  logic [DELAY_W-1:0] dly_q, dly_d, dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0] wid_q, wid_d, gap_q, gap_d, wcnt_q, wcnt_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
  logic [1:0] mode_q, mode_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic tp_q, tp_d, pulse_q, pulse_d, done_q, done_d;
  logic ts, trig;
  assign ts = sync_q[SYNC_STAGES-1];
  assign trig = mode_q[1] ? (ts ^ mode_q[0]) : (mode_q[0] ? (~ts & tp_q) : (ts & ~tp_q));
  assign pulse_o = pulse_q;
  assign done_o = done_q;
  assign armed_o = state_q == ARMED;
  assign busy_o = (state_q == DELAY) | (state_q == PULSE) | (state_q == GAP);
  assign pulse_en_o = armed_o | busy_o;
  always_comb begin
    state_d = state_q;
    dly_d = dly_q;
    wid_d = wid_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    dcnt_d = dcnt_q;
    wcnt_d = wcnt_q;
    pcnt_d = pcnt_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], trigger_i};
    tp_d = ts;
    done_d = 1'b0;
    if (disarm_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (arm_i) begin
        state_d = ARMED;
        dly_d = cfg_delay_i;
        wid_d = cfg_width_i == '0 ? '0 : cfg_width_i - 1'b1;
        gap_d = cfg_gap_i == '0 ? '0 : cfg_gap_i - 1'b1;
        cnt_d = cfg_count_i == '0 ? '0 : cfg_count_i - 1'b1;
        mode_d = cfg_mode_i;
      end
      ARMED: if (trig) begin
        state_d = dly_q == '0 ? PULSE : DELAY;
        dcnt_d = dly_q - 1'b1;
        wcnt_d = wid_q;
        pcnt_d = cnt_q;
      end
      DELAY: if (dcnt_q == '0) begin
        state_d = PULSE;
        wcnt_d = wid_q;
      end else dcnt_d = dcnt_q - 1'b1;
      PULSE: if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
      else if (pcnt_q == '0) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else begin
        state_d = GAP;
        wcnt_d = gap_q;
        pcnt_d = pcnt_q - 1'b1;
      end
      GAP: if (wcnt_q == '0) begin
        state_d = PULSE;
        wcnt_d = wid_q;
      end else wcnt_d = wcnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    pulse_d = state_d == PULSE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dly_q <= '0;
      wid_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
      dcnt_q <= '0;
      wcnt_q <= '0;
      pcnt_q <= '0;
      sync_q <= '0;
      tp_q <= 1'b0;
      pulse_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q <= dly_d;
      wid_q <= wid_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      dcnt_q <= dcnt_d;
      wcnt_q <= wcnt_d;
      pcnt_q <= pcnt_d;
      sync_q <= sync_d;
      tp_q <= tp_d;
      pulse_q <= pulse_d;
      done_q <= done_d;
    end
  end
endmodule
